// File: rtl/motion_scheduler.sv
// Motor step sequencer: turns wall-follower forward/rotate requests into tick-timed motor pulses
// with a settle gap, head-obstacle abort, emergency stop and rotation-loop (stuck) detection.
module motion_scheduler #(
    parameter int unsigned FWD_TICKS    = 4,
    parameter int unsigned ROT_TICKS    = 2,
    parameter int unsigned SETTLE_TICKS = 1,
    parameter int unsigned MAX_ROT      = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               tick,
    input  logic                               front_req,
    input  logic                               rotate_req,
    input  logic                               head,
    input  logic                               estop,
    input  logic                               clear,
    output logic                               motor_fwd,
    output logic                               motor_rot,
    output logic                               busy,
    output logic                               step_done,
    output logic                               stuck,
    output logic [$clog2(MAX_ROT + 1) - 1 : 0] rot_count
);

    localparam int unsigned RC_W = $clog2(MAX_ROT + 1);
    localparam int unsigned MAX_FR = (FWD_TICKS > ROT_TICKS) ? FWD_TICKS : ROT_TICKS;
    localparam int unsigned MAX_TICKS = (MAX_FR > SETTLE_TICKS) ? MAX_FR : SETTLE_TICKS;
    // A 1-bit counter is kept even when every duration is a single tick.
    localparam int unsigned CNT_W = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

    localparam logic [CNT_W-1:0] FWD_LAST    = CNT_W'(FWD_TICKS - 1);
    localparam logic [CNT_W-1:0] ROT_LAST    = CNT_W'(ROT_TICKS - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_TICKS - 1);
    localparam logic [RC_W-1:0]  ROT_LIMIT   = RC_W'(MAX_ROT);
    localparam logic [RC_W-1:0]  ROT_PRELIM  = RC_W'(MAX_ROT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StFwd,
        StRot,
        StSettle,
        StHalt
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [RC_W-1:0]   rot_d;
    logic              stuck_d;
    logic              done_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rot_d   = rot_count;
        stuck_d = stuck;
        done_d  = 1'b0;

        if (estop) begin
            state_d = StHalt;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (rotate_req) begin
                        state_d = StRot;
                    end else if (front_req) begin
                        state_d = StFwd;
                    end
                end
                StFwd: begin
                    // Head obstacle aborts immediately; rot_count is kept for aborted steps.
                    if (head) begin
                        state_d = StSettle;
                        cnt_d   = '0;
                    end else if (tick) begin
                        if (cnt_q == FWD_LAST) begin
                            state_d = StSettle;
                            cnt_d   = '0;
                            rot_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                StRot: begin
                    if (tick) begin
                        if (cnt_q == ROT_LAST) begin
                            cnt_d = '0;
                            if (rot_count == ROT_PRELIM) begin
                                rot_d   = ROT_LIMIT;
                                stuck_d = 1'b1;
                                state_d = StHalt;
                            end else begin
                                rot_d   = rot_count + RC_W'(1);
                                state_d = StSettle;
                            end
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                StSettle: begin
                    if (tick) begin
                        if (cnt_q == SETTLE_LAST) begin
                            state_d = StIdle;
                            cnt_d   = '0;
                            done_d  = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                StHalt: begin
                    if (clear) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                        rot_d   = '0;
                        stuck_d = 1'b0;
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they line up with the registered state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            rot_count <= '0;
            stuck     <= 1'b0;
            step_done <= 1'b0;
            motor_fwd <= 1'b0;
            motor_rot <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rot_count <= rot_d;
            stuck     <= stuck_d;
            step_done <= done_d;
            motor_fwd <= (state_d == StFwd);
            motor_rot <= (state_d == StRot);
            busy      <= (state_d != StIdle);
        end
    end

endmodule

// File: tb/tb_motion_scheduler.sv
// Directed self-checking bench for motion_scheduler with default parameters
// (FWD_TICKS=4, ROT_TICKS=2, SETTLE_TICKS=1, MAX_ROT=4).
module tb_motion_scheduler;

    logic       clk;
    logic       rst_n;
    logic       tick;
    logic       front_req;
    logic       rotate_req;
    logic       head;
    logic       estop;
    logic       clear;
    logic       motor_fwd;
    logic       motor_rot;
    logic       busy;
    logic       step_done;
    logic       stuck;
    logic [2:0] rot_count;

    int checks;
    int failures;

    logic       fwd_s  [0:20];
    logic       rot_s  [0:20];
    logic       done_s [0:20];
    logic       stk_s  [0:20];
    logic       busy_s [0:20];
    logic [2:0] rc_s   [0:20];

    motion_scheduler dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick       (tick),
        .front_req  (front_req),
        .rotate_req (rotate_req),
        .head       (head),
        .estop      (estop),
        .clear      (clear),
        .motor_fwd  (motor_fwd),
        .motor_rot  (motor_rot),
        .busy       (busy),
        .step_done  (step_done),
        .stuck      (stuck),
        .rot_count  (rot_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input int k);
        fwd_s[k]  = motor_fwd;
        rot_s[k]  = motor_rot;
        done_s[k] = step_done;
        stk_s[k]  = stuck;
        busy_s[k] = busy;
        rc_s[k]   = rot_count;
    endtask

    task automatic go_idle();
        front_req  = 1'b0;
        rotate_req = 1'b0;
        estop      = 1'b1;
        cyc();
        estop = 1'b0;
        clear = 1'b1;
        cyc();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        cyc();
        cyc();
        checks++;
        if ({motor_fwd, motor_rot, busy, step_done, stuck} !== 5'b0) begin
            failures++;
            $display("FAIL reset_outputs: got %b expected 00000",
                     {motor_fwd, motor_rot, busy, step_done, stuck});
        end
        checks++;
        if (rot_count !== 3'd0) begin
            failures++;
            $display("FAIL reset_rot_count: got %0d expected 0", rot_count);
        end
    endtask

    task automatic test_reset_mid_fwd();
        rst_n     = 1'b1;
        tick      = 1'b1;
        front_req = 1'b1;
        cyc();
        checks++;
        if (motor_fwd !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL rmf_enter_fwd: got fwd=%b busy=%b expected fwd=1 busy=1",
                     motor_fwd, busy);
        end
        cyc();
        cyc();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({motor_fwd, motor_rot, busy, step_done, stuck} !== 5'b0 || rot_count !== 3'd0) begin
            failures++;
            $display("FAIL rmf_async_reset: got %b rc=%0d expected 00000 rc=0",
                     {motor_fwd, motor_rot, busy, step_done, stuck}, rot_count);
        end
        front_req = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
        checks++;
        if (busy !== 1'b0 || motor_fwd !== 1'b0 || rot_count !== 3'd0) begin
            failures++;
            $display("FAIL rmf_idle_after: got busy=%b fwd=%b rc=%0d expected 0 0 0",
                     busy, motor_fwd, rot_count);
        end
    endtask

    task automatic test_fwd_timing();
        int fwd_cnt;
        int done_cnt;
        int rot_cnt;
        fwd_cnt   = 0;
        done_cnt  = 0;
        rot_cnt   = 0;
        front_req = 1'b1;
        for (int k = 0; k <= 20; k++) begin
            tick = ((k % 4) == 3);
            cyc();
            sample(k);
        end
        tick = 1'b0;
        for (int k = 0; k <= 19; k++) begin
            if (fwd_s[k] === 1'b1) fwd_cnt++;
            if (done_s[k] === 1'b1) done_cnt++;
            if (rot_s[k] === 1'b1) rot_cnt++;
        end
        checks++;
        if (fwd_cnt != 15) begin
            failures++;
            $display("FAIL fwd_high_cycles: got %0d expected 15", fwd_cnt);
        end
        checks++;
        if (fwd_s[14] !== 1'b1 || fwd_s[15] !== 1'b0) begin
            failures++;
            $display("FAIL fwd_drop_edge: got [14]=%b [15]=%b expected 1 0", fwd_s[14], fwd_s[15]);
        end
        checks++;
        if (done_cnt != 1 || done_s[19] !== 1'b1) begin
            failures++;
            $display("FAIL fwd_step_done: got count=%0d at19=%b expected 1 1", done_cnt, done_s[19]);
        end
        checks++;
        if (busy_s[18] !== 1'b1 || busy_s[19] !== 1'b0) begin
            failures++;
            $display("FAIL fwd_settle_busy: got [18]=%b [19]=%b expected 1 0", busy_s[18], busy_s[19]);
        end
        checks++;
        if (fwd_s[20] !== 1'b1 || done_s[20] !== 1'b0 || rot_cnt != 0) begin
            failures++;
            $display("FAIL fwd_restart: got fwd=%b done=%b rot=%0d expected 1 0 0",
                     fwd_s[20], done_s[20], rot_cnt);
        end
        go_idle();
    endtask

    task automatic test_both_req();
        int rot_cnt;
        int fwd_cnt;
        rot_cnt    = 0;
        fwd_cnt    = 0;
        tick       = 1'b1;
        front_req  = 1'b1;
        rotate_req = 1'b1;
        for (int k = 0; k <= 3; k++) begin
            cyc();
            sample(k);
            front_req  = 1'b0;
            rotate_req = 1'b0;
        end
        for (int k = 0; k <= 3; k++) begin
            if (rot_s[k] === 1'b1) rot_cnt++;
            if (fwd_s[k] === 1'b1) fwd_cnt++;
        end
        checks++;
        if (rot_s[0] !== 1'b1 || rot_cnt != 2 || fwd_cnt != 0) begin
            failures++;
            $display("FAIL both_rot_priority: got rot0=%b rot=%0d fwd=%0d expected 1 2 0",
                     rot_s[0], rot_cnt, fwd_cnt);
        end
        checks++;
        if (rc_s[1] !== 3'd0 || rc_s[2] !== 3'd1 || done_s[3] !== 1'b1) begin
            failures++;
            $display("FAIL both_count_done: got rc1=%0d rc2=%0d done3=%b expected 0 1 1",
                     rc_s[1], rc_s[2], done_s[3]);
        end
        go_idle();
    endtask

    task automatic test_stuck();
        int done_cnt;
        done_cnt   = 0;
        tick       = 1'b1;
        rotate_req = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            cyc();
            sample(k);
        end
        for (int k = 0; k <= 16; k++) begin
            if (done_s[k] === 1'b1) done_cnt++;
        end
        checks++;
        if (done_cnt != 3 || done_s[3] !== 1'b1 || done_s[7] !== 1'b1 || done_s[11] !== 1'b1) begin
            failures++;
            $display("FAIL stuck_step_dones: got count=%0d expected 3 at 3,7,11", done_cnt);
        end
        checks++;
        if (rc_s[3] !== 3'd1 || rc_s[7] !== 3'd2 || rc_s[11] !== 3'd3 || rc_s[14] !== 3'd4) begin
            failures++;
            $display("FAIL stuck_rot_count: got %0d %0d %0d %0d expected 1 2 3 4",
                     rc_s[3], rc_s[7], rc_s[11], rc_s[14]);
        end
        checks++;
        if (stk_s[13] !== 1'b0 || stk_s[14] !== 1'b1 || stk_s[16] !== 1'b1) begin
            failures++;
            $display("FAIL stuck_flag: got [13]=%b [14]=%b [16]=%b expected 0 1 1",
                     stk_s[13], stk_s[14], stk_s[16]);
        end
        checks++;
        if (busy_s[16] !== 1'b1 || rot_s[15] !== 1'b0 || rot_s[16] !== 1'b0 || fwd_s[16] !== 1'b0) begin
            failures++;
            $display("FAIL stuck_halt: got busy=%b rot=%b fwd=%b expected 1 0 0",
                     busy_s[16], rot_s[16], fwd_s[16]);
        end
        rotate_req = 1'b0;
        clear      = 1'b1;
        cyc();
        clear = 1'b0;
        checks++;
        if (stuck !== 1'b0 || rot_count !== 3'd0 || busy !== 1'b0 || step_done !== 1'b0) begin
            failures++;
            $display("FAIL stuck_clear: got stuck=%b rc=%0d busy=%b done=%b expected 0 0 0 0",
                     stuck, rot_count, busy, step_done);
        end
    endtask

    task automatic test_head_abort();
        tick       = 1'b1;
        rotate_req = 1'b1;
        for (int k = 0; k < 8; k++) cyc();
        rotate_req = 1'b0;
        checks++;
        if (rot_count !== 3'd2 || busy !== 1'b0) begin
            failures++;
            $display("FAIL head_setup: got rc=%0d busy=%b expected 2 0", rot_count, busy);
        end
        front_req = 1'b1;
        for (int k = 0; k <= 4; k++) begin
            head = (k == 3);
            cyc();
            sample(k);
            front_req = 1'b0;
        end
        head = 1'b0;
        checks++;
        if (fwd_s[2] !== 1'b1 || fwd_s[3] !== 1'b0 || busy_s[3] !== 1'b1) begin
            failures++;
            $display("FAIL head_abort_drop: got fwd2=%b fwd3=%b busy3=%b expected 1 0 1",
                     fwd_s[2], fwd_s[3], busy_s[3]);
        end
        checks++;
        if (done_s[3] !== 1'b0 || done_s[4] !== 1'b1 || busy_s[4] !== 1'b0) begin
            failures++;
            $display("FAIL head_abort_done: got done3=%b done4=%b busy4=%b expected 0 1 0",
                     done_s[3], done_s[4], busy_s[4]);
        end
        checks++;
        if (rc_s[4] !== 3'd2) begin
            failures++;
            $display("FAIL head_rot_kept: got %0d expected 2", rc_s[4]);
        end
    endtask

    task automatic test_estop_rot();
        tick       = 1'b1;
        rotate_req = 1'b1;
        cyc();
        rotate_req = 1'b0;
        checks++;
        if (motor_rot !== 1'b1) begin
            failures++;
            $display("FAIL estop_enter_rot: got %b expected 1", motor_rot);
        end
        estop = 1'b1;
        cyc();
        checks++;
        if (motor_rot !== 1'b0 || busy !== 1'b1 || rot_count !== 3'd2 || step_done !== 1'b0) begin
            failures++;
            $display("FAIL estop_halt: got rot=%b busy=%b rc=%0d done=%b expected 0 1 2 0",
                     motor_rot, busy, rot_count, step_done);
        end
        clear = 1'b1;
        cyc();
        checks++;
        if (busy !== 1'b1 || rot_count !== 3'd2) begin
            failures++;
            $display("FAIL estop_clear_ignored: got busy=%b rc=%0d expected 1 2", busy, rot_count);
        end
        estop = 1'b0;
        cyc();
        clear = 1'b0;
        checks++;
        if (busy !== 1'b0 || rot_count !== 3'd0 || motor_rot !== 1'b0) begin
            failures++;
            $display("FAIL estop_release: got busy=%b rc=%0d rot=%b expected 0 0 0",
                     busy, rot_count, motor_rot);
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst_n      = 1'b0;
        tick       = 1'b0;
        front_req  = 1'b0;
        rotate_req = 1'b0;
        head       = 1'b0;
        estop      = 1'b0;
        clear      = 1'b0;
        test_reset();
        test_reset_mid_fwd();
        test_fwd_timing();
        test_both_req();
        test_stuck();
        test_head_abort();
        test_estop_rot();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/motion_scheduler.md
Name: motion_scheduler

Overview:
Sequences the robot's motor actuation from the wall-following FSM's front/rotate requests. Converts each request into a timed motor step measured in divided-clock ticks, with a settle gap between steps. Aborts forward motion on a head obstacle and detects rotation loops (stuck robot). Sits between the moore/mealy wall-follower outputs and the motor drivers; counts tick pulses produced by the clock divider.

Parameters:
FWD_TICKS, 4, ticks motor_fwd is held per forward step (>=1)
ROT_TICKS, 2, ticks motor_rot is held per rotate step (>=1)
SETTLE_TICKS, 1, ticks of motors-off gap after every step (>=1)
MAX_ROT, 4, consecutive completed rotations that flag stuck (>=1)

Ports:
clk  in  1  system clock, all logic rising-edge
rst_n  in  1  asynchronous active-low reset
tick  in  1  one-cycle enable pulse from clock divider; all durations count cycles with tick=1
front_req  in  1  level request for a forward step (from wall-follower FSM)
rotate_req  in  1  level request for a rotate step
head  in  1  front obstacle sensor, 1 = blocked
estop  in  1  emergency stop, level
clear  in  1  exits HALT (sampled only in HALT)
motor_fwd  out  1  forward motor drive
motor_rot  out  1  rotate motor drive
busy  out  1  1 in any state except IDLE
step_done  out  1  one-cycle pulse on each completed step
stuck  out  1  sticky rotation-loop flag
rot_count  out  clog2(MAX_ROT+1)  consecutive completed rotations

Behaviour:
- Reset (async, rst_n=0): state IDLE, tick counter 0, rot_count 0; all outputs 0.
- All outputs registered; motor_fwd=1 exactly while state=FWD, motor_rot=1 exactly while state=ROT; both never 1 together.
- States: IDLE, FWD, ROT, SETTLE, HALT.
- estop=1 in any state: next state HALT, counter cleared, motors off from next cycle; highest priority over everything.
- IDLE: rotate_req=1 -> ROT (rotate wins if both requests high); else front_req=1 -> FWD; else stay. Requests sampled only in IDLE; changes during a step ignored.
- ROT entry: no count change. FWD entry while head=1: allowed, aborts next cycle (see below).
- FWD: counter increments on tick; on tick with counter=FWD_TICKS-1 -> SETTLE, counter 0, rot_count cleared to 0. If head=1 (and no estop) -> SETTLE immediately, counter 0, rot_count unchanged (aborted step still produces step_done).
- ROT: counter increments on tick; on tick with counter=ROT_TICKS-1 -> rot_count+1; if new value = MAX_ROT -> stuck=1, HALT (no step_done); else SETTLE, counter 0.
- SETTLE: motors off; on tick with counter=SETTLE_TICKS-1 -> IDLE, counter 0, step_done=1 for exactly the first IDLE cycle.
- HALT: motors off, busy=1. If estop=0 and clear=1 -> IDLE, stuck=0, rot_count=0, counter 0. clear while estop=1 ignored.
- Counter width clog2(max(FWD_TICKS,ROT_TICKS,SETTLE_TICKS)); never exceeds param-1; no wrap.
- tick=0 freezes all duration counting; state transitions on head/estop/requests do not need tick.
- rot_count saturates at MAX_ROT (reached only together with HALT).

Test Plan:
- Reset mid-FWD (tick every cycle, rst_n pulled low at step cycle 2) -> all outputs 0 immediately, IDLE after release, rot_count 0.
- tick every 4 cycles, front_req=1 held, defaults -> motor_fwd high for exactly 4 ticks (16 cycles +/- entry phase), 4 cycles off, step_done single-cycle pulse, next FWD starts.
- front_req=rotate_req=1 in IDLE -> ROT chosen; motor_rot 2 ticks; rot_count=1; motor_fwd never asserted.
- rotate_req held, front_req=0, MAX_ROT=4 -> rot_count 1,2,3 with step_done each, 4th rotation -> stuck=1, HALT, no 4th step_done; clear=1 -> IDLE, stuck=0, rot_count=0.
- FWD in progress, head=1 at tick 2 -> motor_fwd drops next cycle, SETTLE, step_done after 1 tick, rot_count unchanged (set to 2 beforehand, stays 2).
- estop=1 during ROT -> motor_rot 0 next cycle, HALT; clear=1 with estop=1 stays HALT; estop=0 + clear=1 -> IDLE.
